disassembler: RTL and testbench
===============================

// Module: disassembler
// PURPOSE
//  Receive-side counterpart of the solution assembler. Consumes the byte stream produced by uart_rx and
//  rebuilds the framed grid message: m, n, one row bitmap per row, then a stop word.
//  Outputs the unpacked 11x11 grid, m, and n, plus a one-cycle valid pulse.
//  Malformed or stalled frames produce an error pulse, and the block resynchronises.
//  Sits between uart_rx and the solver input / loopback checker.
// PARAMETERS
//  MAX_DIM    11           max rows/cols; solution width is MAX_DIM*MAX_DIM
//  DIM_W      4            width of m and n
//  STOP_WORD  16'hFFFF     frame terminator word
//  TIMEOUT    1_000_000    idle clk cycles allowed mid-frame before abort
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous, active-high reset
//  valid_in   in   1      byte_in valid this cycle (one byte per asserted cycle)
//  byte_in    in   8      received byte
//  solution   out  121    grid; row r at [r*11 +: 11], bit c = column c
//  m          out  4      columns of last good frame
//  n          out  4      rows of last good frame
//  valid_out  out  1      1-cycle pulse: solution/m/n updated
//  error      out  1      1-cycle pulse: frame rejected
//  busy       out  1      high while a frame is partially received
// BEHAVIOUR
//  Framing
//  - Every message is one 16-bit word, sent as 2 bytes, MSB first. A hi/lo phase bit tracks the byte position.
//  - Frame order: word m, word n, rows 0..n-1, STOP_WORD.
//  - m and n are taken from word bits [3:0]. Row bits come from word bits [10:0]; bits >= m are masked to 0.
//  FSM states: S_M -> S_N -> S_ROW -> S_STOP -> S_M.
//  - S_N advances to S_ROW; the row counter is cleared to 0.
//  - S_ROW stays until the counter reaches n-1.
//  - Each state advances only on a completed (lo-byte) word.
//  Reset
//  - All outputs are 0. State is S_M, phase is hi, and the shadow grid and counters are cleared.
//  Grid buffering
//  - Rows are written to a shadow grid, which is cleared on entry to S_N.
//  - solution, m and n load from the shadow only on a good stop word.
//  - Outputs hold the last good frame otherwise.
//  Latency
//  - valid_out rises in the cycle after the valid_in cycle carrying the final stop byte.
//  - The new solution, m and n are visible in that same cycle.
//  Error: pulse error for 1 cycle, return to S_M with phase hi, and discard the shadow. Causes:
//  - m or n equal to 0 or greater than MAX_DIM (checked when the word completes).
//  - The word in S_STOP is not STOP_WORD.
//  - A partial frame or partial word sees TIMEOUT consecutive cycles without valid_in.
//  Other rules
//  - The timeout counter resets on every valid_in and is held at 0 in S_M with phase hi.
//  - busy = !(state == S_M && phase == hi).
//  - valid_out and error are never high in the same cycle.
//  - rst mid-frame: the partial frame is dropped silently (no error pulse); the previous solution is cleared to 0.
//  - Back-to-back frames: valid_in may be high every cycle, including the cycle after the stop byte. No gap is required.
// STRUCTURE
//  - A shared package (nonogram_pkg) holds MAX_DIM, DIM_W, STOP_WORD and the state enum.
//  - It also holds the row index function r*MAX_DIM, shared with the assembler.
//  - One sub-module, word_framer, pairs bytes into 16-bit words.
//  - word_framer owns the phase bit and the timeout counter.
//  - Its outputs are word, word_valid and timeout pulses.
//  - The FSM, row counter and shadow grid live in the top module.
// TESTING
//  1. Good 3x3 frame. Bytes: 00 03 00 03 00 03 00 02 00 05 FF FF.
//     -> one valid_out; solution = {88'b0, 33'h1401003}; m = 3; n = 3; error never.
//  2. 11x11 frame, all rows 0x07FF, then an immediate second 1x1 frame (row 0x0001) with no gap.
//     -> first pulse: solution all ones. Second pulse: solution = 121'h1, m = 1, n = 1.
//  3. m word 00 0C (12).
//     -> error pulse after the 2nd byte; the next good 3x3 frame is still accepted. Also a 3x3 frame ending 12 34.
//     -> error; solution unchanged from the prior good frame.
//  4. Row word 07 FF with m = 3.
//     -> that row stored as 0x007 (masking).
//  5. Frame stopped after byte 5, then TIMEOUT idle cycles (TIMEOUT overridden to 16 in the bench).
//     -> error pulse at cycle 16; busy falls; a subsequent good frame decodes.
//  6. rst asserted mid-row.
//     -> next cycle all outputs are 0 and busy is 0; no error pulse; a following good frame decodes.

Source files
------------

// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram grid link: dimensions, frame terminator,
// receive FSM states and grid indexing helpers shared with the assembler.
package nonogram_pkg;

  localparam int          MAX_DIM   = 11;
  localparam int          DIM_W     = 4;
  localparam logic [15:0] STOP_WORD = 16'hFFFF;
  localparam int          GRID_W    = MAX_DIM * MAX_DIM;
  localparam int          IDX_W     = $clog2(GRID_W);

  typedef enum logic [1:0] {
    S_M,
    S_N,
    S_ROW,
    S_STOP
  } state_t;

  function automatic logic [IDX_W-1:0] row_base(input logic [DIM_W-1:0] r);
    return IDX_W'(r) * IDX_W'(MAX_DIM);
  endfunction

  function automatic logic [MAX_DIM-1:0] col_mask(input logic [DIM_W-1:0] m);
    logic [MAX_DIM-1:0] mask;
    for (int c = 0; c < MAX_DIM; c++) mask[c] = (c < int'(m));
    return mask;
  endfunction

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (d > DIM_W'(MAX_DIM));
  endfunction

endpackage

// File: rtl/word_framer.sv
// Pairs received bytes (MSB first) into 16-bit words and watches for a
// stalled frame; the idle timer is a down-counter reloaded on every byte.
module word_framer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [7:0]  byte_in,
  input  logic        frame_open,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        timeout,
  output logic        phase_hi
);

  localparam int              TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  logic [7:0]      hi_byte;
  logic [TO_W-1:0] idle_cnt;
  logic            busy_int;

  assign busy_int   = frame_open || !phase_hi;
  assign word       = {hi_byte, byte_in};
  assign word_valid = valid_in && !phase_hi;
  // Fires during the TIMEOUT-th consecutive idle cycle of an open frame.
  assign timeout    = busy_int && !valid_in && (idle_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_hi <= 1'b1;
      hi_byte  <= '0;
      idle_cnt <= TO_LOAD;
    end else begin
      if (timeout) begin
        phase_hi <= 1'b1;
      end else if (valid_in) begin
        if (phase_hi) hi_byte <= byte_in;
        phase_hi <= !phase_hi;
      end

      if (valid_in || !busy_int) idle_cnt <= TO_LOAD;
      else if (idle_cnt != '0)   idle_cnt <= idle_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/disassembler.sv
// Rebuilds framed grid messages (m, n, n row bitmaps, stop word) from the
// uart_rx byte stream into a double-buffered 11x11 grid.
//
// state  | meaning
// S_M    | idle / waiting for the column-count word
// S_N    | waiting for the row-count word
// S_ROW  | receiving row bitmaps 0..n-1 into the shadow grid
// S_STOP | expecting the terminator word
module disassembler
  import nonogram_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [7:0]        byte_in,
  output logic [GRID_W-1:0] solution,
  output logic [DIM_W-1:0]  m,
  output logic [DIM_W-1:0]  n,
  output logic              valid_out,
  output logic              error,
  output logic              busy
);

  state_t            state;
  logic [DIM_W-1:0]  row_cnt;
  logic [DIM_W-1:0]  m_sh;
  logic [DIM_W-1:0]  n_sh;
  logic [GRID_W-1:0] shadow;
  logic [15:0]       word;
  logic              word_valid;
  logic              timeout;
  logic              phase_hi;

  word_framer #(.TIMEOUT(TIMEOUT)) u_framer (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .byte_in    (byte_in),
    .frame_open (state != S_M),
    .word       (word),
    .word_valid (word_valid),
    .timeout    (timeout),
    .phase_hi   (phase_hi)
  );

  assign busy = (state != S_M) || !phase_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_M;
      row_cnt   <= '0;
      m_sh      <= '0;
      n_sh      <= '0;
      shadow    <= '0;
      solution  <= '0;
      m         <= '0;
      n         <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      error     <= 1'b0;
      if (timeout) begin
        error  <= 1'b1;
        state  <= S_M;
        shadow <= '0;
      end else if (word_valid) begin
        unique case (state)
          S_M: begin
            if (dim_bad(word[DIM_W-1:0])) begin
              error <= 1'b1;
            end else begin
              m_sh   <= word[DIM_W-1:0];
              shadow <= '0;
              state  <= S_N;
            end
          end
          S_N: begin
            if (dim_bad(word[DIM_W-1:0])) begin
              error  <= 1'b1;
              shadow <= '0;
              state  <= S_M;
            end else begin
              n_sh    <= word[DIM_W-1:0];
              row_cnt <= '0;
              state   <= S_ROW;
            end
          end
          S_ROW: begin
            shadow[row_base(row_cnt) +: MAX_DIM] <= word[MAX_DIM-1:0] & col_mask(m_sh);
            if (row_cnt == n_sh - 1'b1) state <= S_STOP;
            else                        row_cnt <= row_cnt + 1'b1;
          end
          S_STOP: begin
            if (word == STOP_WORD) begin
              solution  <= shadow;
              m         <= m_sh;
              n         <= n_sh;
              valid_out <= 1'b1;
            end else begin
              error  <= 1'b1;
              shadow <= '0;
            end
            state <= S_M;
          end
          default: state <= S_M;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disassembler.sv
// Directed bench for disassembler: a table of whole frames with expected
// grid/pulses, then hand sequences for back-to-back, timeout and reset cases.
module tb_disassembler;
  import nonogram_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [7:0]        byte_in;
  logic [GRID_W-1:0] solution;
  logic [DIM_W-1:0]  m;
  logic [DIM_W-1:0]  n;
  logic              valid_out;
  logic              error;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int nv, ne, both;

  disassembler #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .byte_in   (byte_in),
    .solution  (solution),
    .m         (m),
    .n         (n),
    .valid_out (valid_out),
    .error     (error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           len;
    logic [127:0] data;
    int           exp_v;
    int           exp_e;
    logic [120:0] exp_sol;
    logic [3:0]   exp_m;
    logic [3:0]   exp_n;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tally();
    if (valid_out === 1'b1) nv++;
    if (error === 1'b1) ne++;
    if (valid_out === 1'b1 && error === 1'b1) both++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    valid_in = 1'b1;
    byte_in  = b;
    @(posedge clk); #1;
    tally();
  endtask

  task automatic idle(input int cycles);
    valid_in = 1'b0;
    byte_in  = 8'h00;
    repeat (cycles) begin
      @(posedge clk); #1;
      tally();
    end
  endtask

  task automatic send_frame(input int len, input logic [127:0] data);
    for (int k = 0; k < len; k++) send_byte(data[(len-1-k)*8 +: 8]);
  endtask

  initial begin
    int first_err;

    vecs[0] = '{12, 128'h0003_0003_0003_0002_0005_FFFF, 1, 0, 121'h1401003, 4'd3, 4'd3};
    vecs[1] = '{2,  128'h000C,                          0, 1, 121'h1401003, 4'd3, 4'd3};
    vecs[2] = '{10, 128'h0003_0002_0001_0006_FFFF,      1, 0, 121'h3001,    4'd3, 4'd2};
    vecs[3] = '{12, 128'h0003_0003_0001_0002_0004_1234, 0, 1, 121'h3001,    4'd3, 4'd2};
    vecs[4] = '{8,  128'h0003_0001_07FF_FFFF,           1, 0, 121'h7,       4'd3, 4'd1};
    vecs[5] = '{4,  128'h0005_0000,                     0, 1, 121'h7,       4'd3, 4'd1};
    vecs[6] = '{2,  128'h0000,                          0, 1, 121'h7,       4'd3, 4'd1};
    vecs[7] = '{10, 128'h000B_0002_0400_0001_FFFF,      1, 0, 121'hC00,     4'd11, 4'd2};
    vecs[8] = '{4,  128'h0002_000C,                     0, 1, 121'hC00,     4'd11, 4'd2};

    nv = 0; ne = 0; both = 0;
    rst = 1'b1; valid_in = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_solution", 128'(solution), 128'h0);
    chk("reset_mn",       128'({m, n}),   128'h0);
    chk("reset_pulses",   128'({valid_out, error, busy}), 128'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      nv = 0; ne = 0;
      send_frame(vecs[i].len, vecs[i].data);
      idle(1);
      chk($sformatf("vec%0d_valid_cnt", i), 128'(nv), 128'(vecs[i].exp_v));
      chk($sformatf("vec%0d_error_cnt", i), 128'(ne), 128'(vecs[i].exp_e));
      chk($sformatf("vec%0d_solution", i),  128'(solution), 128'(vecs[i].exp_sol));
      chk($sformatf("vec%0d_m", i),         128'(m), 128'(vecs[i].exp_m));
      chk($sformatf("vec%0d_n", i),         128'(n), 128'(vecs[i].exp_n));
      chk($sformatf("vec%0d_busy", i),      128'(busy), 128'h0);
    end

    // 11x11 all ones, then a 1x1 frame with no gap after the stop byte
    nv = 0; ne = 0;
    send_frame(4, 128'h000B_000B);
    for (int r = 0; r < 11; r++) send_frame(2, 128'h07FF);
    send_frame(2, 128'hFFFF);
    chk("full_valid_latency", 128'(valid_out), 128'h1);
    chk("full_solution", 128'(solution), 128'({121{1'b1}}));
    chk("full_mn", 128'({m, n}), 128'h BB);
    send_frame(8, 128'h0001_0001_0001_FFFF);
    chk("b2b_valid_latency", 128'(valid_out), 128'h1);
    idle(1);
    chk("b2b_solution", 128'(solution), 128'h1);
    chk("b2b_mn", 128'({m, n}), 128'h11);
    chk("b2b_counts", 128'({nv, ne}), {64'h0, 32'd2, 32'd0});

    // Stall after five bytes; error must land on the 16th idle cycle
    nv = 0; ne = 0;
    send_frame(5, 128'h00_0300_0300);
    chk("stall_busy", 128'(busy), 128'h1);
    first_err = 0;
    valid_in = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      tally();
      if (error === 1'b1 && first_err == 0) first_err = i;
    end
    chk("timeout_cycle", 128'(first_err), 128'd16);
    chk("timeout_err_cnt", 128'(ne), 128'd1);
    chk("timeout_busy", 128'(busy), 128'h0);
    chk("timeout_sol_held", 128'(solution), 128'h1);
    nv = 0;
    send_frame(12, 128'h0003_0003_0003_0002_0005_FFFF);
    idle(1);
    chk("after_timeout_valid", 128'(nv), 128'd1);
    chk("after_timeout_sol", 128'(solution), 128'h1401003);

    // Reset in the middle of a row word
    nv = 0; ne = 0;
    send_frame(7, 128'h00_0300_0300_0300);
    rst = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    tally();
    chk("midrst_solution", 128'(solution), 128'h0);
    chk("midrst_mn_busy", 128'({m, n, busy, valid_out}), 128'h0);
    chk("midrst_no_error", 128'(ne), 128'd0);
    rst = 1'b0;
    send_frame(8, 128'h0003_0001_0005_FFFF);
    idle(1);
    chk("after_rst_valid", 128'(nv), 128'd1);
    chk("after_rst_solution", 128'(solution), 128'h5);
    chk("after_rst_mn", 128'({m, n}), 128'h31);

    chk("never_valid_and_error", 128'(both), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
